// File: rtl/firmware_config_tx.sv
// Transmitting end of the configId/configData bus: streams a buffered firmware image to one receiver ID.
// Optional macro CFG_TX_TRACING_GATE_EN forces tracing low while a transfer is in flight.
module firmware_config_tx #(
    parameter int         MAX_BYTES  = 32,
    parameter logic [7:0] IDLE_ID    = 8'hFF,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tracing_req,
    input  logic                           wr_en,
    input  logic [$clog2(MAX_BYTES)-1:0]   wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic                           start,
    input  logic [7:0]                     target_id,
    input  logic [$clog2(MAX_BYTES+1)-1:0] length,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           tracing,
    output logic [7:0]                     configId,
    output logic [7:0]                     configData
);
    localparam int CW    = $clog2(MAX_BYTES + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W = (CW > GW) ? CW : GW;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND, S_TAIL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    len_q;
    logic [7:0]       tgt_q;
    logic [7:0]       mem_q [MAX_BYTES];

    logic       len_ok, tr_block, accept, reject;
    logic [7:0] rd_byte;
    logic       busy_d, done_d, err_d, tracing_d;
    logic [7:0] cfg_id_d, cfg_data_d;

    always_comb begin
        len_ok = (length != '0) && (length <= CW'(MAX_BYTES));
`ifdef CFG_TX_TRACING_GATE_EN
        tr_block = 1'b0;
`else
        // Without the gate, receivers would see config bytes mixed with live tracing.
        tr_block = tracing_req;
`endif
        accept = (state_q == S_IDLE) && start && len_ok && !tr_block;
        reject = (state_q == S_IDLE) && start && !(len_ok && !tr_block);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts gap cycles in GAP and is the byte index in SEND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
                    state_d = S_TAIL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_TAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (cnt_d == CNT_W'(i)) rd_byte = mem_q[i];
        end
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_TAIL);
        err_d      = reject;
        cfg_id_d   = (state_d == S_SEND) ? tgt_q : IDLE_ID;
        cfg_data_d = (state_d == S_SEND) ? rd_byte : 8'h00;
`ifdef CFG_TX_TRACING_GATE_EN
        tracing_d  = tracing_req && (state_d == S_IDLE);
`else
        tracing_d  = tracing_req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tracing    <= 1'b0;
            configId   <= IDLE_ID;
            configData <= 8'h00;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            tracing    <= tracing_d;
            configId   <= cfg_id_d;
            configData <= cfg_data_d;
        end
    end

    // Image buffer and transfer descriptor are data: retained across reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_q <= target_id;
            len_q <= length;
        end
        if (wr_en && (state_q == S_IDLE)) mem_q[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_firmware_config_tx.sv
// Scoreboard bench for firmware_config_tx: stimulus queues expected bus events, a monitor pops and compares.
module tb_firmware_config_tx;
    localparam int         MAX_BYTES = 32;
    localparam logic [7:0] IDLE      = 8'hFF;
    localparam int         GAP       = 2;
`ifdef CFG_TX_TRACING_GATE_EN
    localparam logic TR_XFER = 1'b1;
`else
    localparam logic TR_XFER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, tracing_req, wr_en, start;
    logic [4:0] wr_addr;
    logic [7:0] wr_data, target_id;
    logic [5:0] length;
    logic       busy, done, err, tracing;
    logic [7:0] configId, configData;

    firmware_config_tx #(.MAX_BYTES(MAX_BYTES), .IDLE_ID(IDLE), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .tracing_req(tracing_req), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .target_id(target_id),
        .length(length), .busy(busy), .done(done), .err(err), .tracing(tracing),
        .configId(configId), .configData(configData)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;   // 0 byte, 1 done, 2 err
        logic [7:0] id;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] img [MAX_BYTES];
    ev_t        mon_act, mon_exp;
    logic       mon_have;

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [7:0] id, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.id = id; e.data = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        img[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] id, input logic [5:0] len);
        start = 1'b1; target_id = id; length = len;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_xfer(input logic [7:0] id, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(mk_ev(2'd0, id, img[i]));
        exp_q.push_back(mk_ev(2'd1, IDLE, 8'h00));
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_configId"},   32'(configId),   32'(IDLE));
        check({tag, "_configData"}, 32'(configData), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_tracing"},    32'(tracing),    32'd0);
    endtask

    // Monitor: every err/done pulse and every non-idle ID cycle must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_have = 1'b0;
            if (err === 1'b1) begin
                mon_act = mk_ev(2'd2, configId, configData); mon_have = 1'b1;
            end else if (done === 1'b1) begin
                mon_act = mk_ev(2'd1, configId, configData); mon_have = 1'b1;
            end else if (configId !== IDLE && configId !== 8'hxx) begin
                mon_act = mk_ev(2'd0, configId, configData); mon_have = 1'b1;
                check("send_tracing_low", 32'(tracing), 32'd0);
            end
            if (mon_have) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got %0h expected none at %0t", mon_act, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("bus_event", 32'(mon_act), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; tracing_req = 1'b0; wr_en = 1'b0; start = 1'b0;
        wr_addr = '0; wr_data = '0; target_id = '0; length = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle: tracing follows the request one cycle late
        tracing_req = 1'b1;
        check("tracing_lag", 32'(tracing), 32'd0);
        tick();
        check("tracing_follow", 32'(tracing), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_configId", 32'(configId), 32'(IDLE));
            check("idle_busy", 32'(busy), 32'd0);
        end
        tracing_req = 1'b0;
        tick();
        check("tracing_drop", 32'(tracing), 32'd0);

        // Four-byte transfer to ID 0 with cycle-exact timeline checks
        for (int i = 0; i < 4; i++) write_byte(5'(i), 8'(8'h10 + i));
        tracing_req = TR_XFER;
        expect_xfer(8'h00, 4);
        start_xfer(8'h00, 6'd4);
        for (int c = 1; c <= 2; c++) begin
            check("gap_busy", 32'(busy), 32'd1);
            check("gap_tracing", 32'(tracing), 32'd0);
            check("gap_configId", 32'(configId), 32'(IDLE));
            tick();
        end
        check("first_byte_id", 32'(configId), 32'd0);
        check("first_byte_data", 32'(configData), 32'h10);
        repeat (4) tick();
        check("tail_done", 32'(done), 32'd1);
        check("tail_configId", 32'(configId), 32'(IDLE));
        tick();
        check("after_busy", 32'(busy), 32'd0);
        check("after_tracing", 32'(tracing), 32'(TR_XFER));
        tracing_req = 1'b0;
        tick();

        // Bad lengths are rejected
        exp_q.push_back(mk_ev(2'd2, IDLE, 8'h00));
        start_xfer(8'h07, 6'd0);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        tick();
        check("err_one_cycle", 32'(err), 32'd0);
        exp_q.push_back(mk_ev(2'd2, IDLE, 8'h00));
        start_xfer(8'h07, 6'd33);
        check("len33_err", 32'(err), 32'd1);
        check("len33_busy", 32'(busy), 32'd0);
        tick();
        check("len33_configId", 32'(configId), 32'(IDLE));

`ifndef CFG_TX_TRACING_GATE_EN
        // Ungated build: a start while tracing is requested is refused
        tracing_req = 1'b1;
        tick();
        exp_q.push_back(mk_ev(2'd2, IDLE, 8'h00));
        start_xfer(8'h00, 6'd4);
        check("trreq_err", 32'(err), 32'd1);
        check("trreq_busy", 32'(busy), 32'd0);
        tick();
        check("trreq_no_xfer", 32'(busy), 32'd0);
        tracing_req = 1'b0;
        tick();
`endif

        // Full 32-byte image; mid-SEND start and write must be ignored
        for (int i = 0; i < MAX_BYTES; i++) write_byte(5'(i), 8'(8'h40 + 3 * i));
        tracing_req = TR_XFER;
        expect_xfer(8'h03, MAX_BYTES);
        start_xfer(8'h03, 6'd32);
        repeat (6) tick();
        start = 1'b1; target_id = 8'h09; length = 6'd2;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 8'hEE;
        tick();
        start = 1'b0; wr_en = 1'b0;
        check("midsend_busy", 32'(busy), 32'd1);
        wait_done();
        expect_xfer(8'h05, 2);
        tick();
        check("busy_fall", 32'(busy), 32'd0);
        start_xfer(8'h05, 6'd2);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done();
        tick();
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset at the second SEND byte aborts; retry sends the unchanged image
        exp_q.push_back(mk_ev(2'd0, 8'h03, img[0]));
        start_xfer(8'h03, 6'd32);
        repeat (3) tick();
        check("abort_byte1_data", 32'(configData), 32'(img[1]));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        rst_n = 1'b1;
        tick();
        expect_xfer(8'h03, MAX_BYTES);
        start_xfer(8'h03, 6'd32);
        wait_done();
        tick();
        check("retry_idle", 32'(busy), 32'd0);

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
